// File: rtl/phv_pkt_deparser.sv
`default_nettype none
// ============================================================================
// Module   : phv_pkt_deparser (with helper phv_dp_fifo)
// Brief    : Writes returned PHV headers back over buffered packet words and
//            drops packets the parser flagged invalid.
// Revision : 1.0 - initial release
// ============================================================================

module phv_dp_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_wr_ok
);
    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;

    // Show-ahead: the head entry is always visible on o_rdata.
    assign w_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_wr_ok = i_wr && !o_full;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (o_wr_ok)          r_wptr <= r_wptr + 1'b1;
            if (i_rd && !w_empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_wr_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

module phv_pkt_deparser #(
    parameter int HEAD_WIDTH    = 512,
    parameter int TAG_WIDTH     = 8,
    parameter int TAG_START_BIT = 0,
    parameter int TAG_TAIL_BIT  = 1,
    parameter int TAG_VALID_BIT = 7,
    parameter int PKT_FIFO_AW   = 9,
    parameter int PHV_FIFO_AW   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_pkt_valid,
    input  logic [133:0]                    i_pkt,
    input  logic                            i_phv_valid,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
    output logic                            o_pkt_valid,
    output logic [133:0]                    o_pkt,
    output logic                            o_err_overflow,
    output logic                            o_err_mismatch,
    output logic [15:0]                     o_drop_cnt
);
    localparam int               c_pkt_num = HEAD_WIDTH / 128;
    localparam int               c_j_w     = (c_pkt_num > 1) ? $clog2(c_pkt_num) : 1;
    localparam logic [c_j_w-1:0] c_j_last  = c_j_w'(c_pkt_num - 1);
    localparam int               c_slice_w = HEAD_WIDTH + 3;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_check = 3'd1;
    localparam logic [2:0] c_st_merge = 3'd2;
    localparam logic [2:0] c_st_flush = 3'd3;
    localparam logic [2:0] c_st_drop  = 3'd4;

    logic [2:0]             r_state;
    logic [c_j_w-1:0]       r_j;
    logic                   r_slice_act;
    logic                   r_pkt_end;
    logic                   r_phv_end;
    logic                   r_pkt_skip;
    logic [PKT_FIFO_AW:0]   r_pkt_done;
    logic [PHV_FIFO_AW:0]   r_phv_done;

    logic                   w_in_head;
    logic                   w_pkt_wr;
    logic                   w_pkt_wr_ok;
    logic                   w_pkt_full;
    logic                   w_pkt_rd;
    logic [133:0]           w_pkt_q;
    logic                   w_pkt_q_tail;
    logic                   w_pkt_last;
    logic [c_slice_w-1:0]   w_phv_wdata;
    logic                   w_phv_wr_ok;
    logic                   w_phv_full;
    logic                   w_phv_rd;
    logic [c_slice_w-1:0]   w_phv_q;
    logic                   w_q_valid;
    logic                   w_q_tail;
    logic                   w_q_start;
    logic                   w_phv_last;
    logic                   w_slice_pop;
    logic [127:0]           w_hdr_word;

    // After reset, words are ignored until a fresh head word shows up.
    assign w_in_head = (i_pkt[133:132] == 2'b01);
    assign w_pkt_wr  = i_pkt_valid && (!r_pkt_skip || w_in_head);

    // Only the three tag bits the deparser acts on are buffered with the header.
    assign w_phv_wdata = {i_phv[HEAD_WIDTH+TAG_VALID_BIT], i_phv[HEAD_WIDTH+TAG_TAIL_BIT],
                          i_phv[HEAD_WIDTH+TAG_START_BIT], i_phv[HEAD_WIDTH-1:0]};
    assign w_q_valid   = w_phv_q[HEAD_WIDTH+2];
    assign w_q_tail    = w_phv_q[HEAD_WIDTH+1];
    assign w_q_start   = w_phv_q[HEAD_WIDTH];

    phv_dp_fifo #(.WIDTH(134), .AW(PKT_FIFO_AW)) u_pkt_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_pkt_wr),
        .i_wdata (i_pkt),
        .i_rd    (w_pkt_rd),
        .o_rdata (w_pkt_q),
        .o_full  (w_pkt_full),
        .o_wr_ok (w_pkt_wr_ok)
    );

    phv_dp_fifo #(.WIDTH(c_slice_w), .AW(PHV_FIFO_AW)) u_phv_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (i_phv_valid),
        .i_wdata (w_phv_wdata),
        .i_rd    (w_phv_rd),
        .o_rdata (w_phv_q),
        .o_full  (w_phv_full),
        .o_wr_ok (w_phv_wr_ok)
    );

    assign w_pkt_q_tail = (w_pkt_q[133:132] == 2'b10);
    assign w_slice_pop  = (r_state == c_st_merge) && r_slice_act && ((r_j == c_j_last) || w_pkt_q_tail);
    assign w_pkt_rd     = (r_state == c_st_merge) || ((r_state == c_st_drop) && !r_pkt_end);
    assign w_phv_rd     = ((r_state == c_st_check) && (r_phv_done != '0) && !w_q_start) ||
                          w_slice_pop || (r_state == c_st_flush) ||
                          ((r_state == c_st_drop) && !r_phv_end);
    assign w_pkt_last   = w_pkt_rd && w_pkt_q_tail;
    assign w_phv_last   = w_phv_rd && w_q_tail;

    always_comb begin
        w_hdr_word = '0;
        for (int k = 0; k < c_pkt_num; k++) begin
            if (int'(r_j) == k) w_hdr_word = w_phv_q[HEAD_WIDTH-1-128*k -: 128];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_skip     <= 1'b1;
            r_pkt_done     <= '0;
            r_phv_done     <= '0;
            o_err_overflow <= 1'b0;
        end else begin
            if (i_pkt_valid && w_in_head) r_pkt_skip <= 1'b0;
            if ((w_pkt_wr && w_pkt_full) || (i_phv_valid && w_phv_full)) o_err_overflow <= 1'b1;
            case ({w_pkt_wr_ok && (i_pkt[133:132] == 2'b10), w_pkt_last})
                2'b10:   r_pkt_done <= r_pkt_done + 1'b1;
                2'b01:   r_pkt_done <= r_pkt_done - 1'b1;
                default: r_pkt_done <= r_pkt_done;
            endcase
            case ({w_phv_wr_ok && i_phv[HEAD_WIDTH+TAG_TAIL_BIT], w_phv_last})
                2'b10:   r_phv_done <= r_phv_done + 1'b1;
                2'b01:   r_phv_done <= r_phv_done - 1'b1;
                default: r_phv_done <= r_phv_done;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= c_st_idle;
            r_j            <= '0;
            r_slice_act    <= 1'b0;
            r_pkt_end      <= 1'b0;
            r_phv_end      <= 1'b0;
            o_pkt_valid    <= 1'b0;
            o_pkt          <= '0;
            o_err_mismatch <= 1'b0;
            o_drop_cnt     <= '0;
        end else begin
            o_pkt_valid    <= 1'b0;
            o_err_mismatch <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if ((r_pkt_done != '0) && (r_phv_done != '0)) r_state <= c_st_check;
                end
                c_st_check: begin
                    if (r_phv_done == '0) begin
                        r_state <= c_st_idle;
                    end else if (!w_q_start) begin
                        o_err_mismatch <= 1'b1;
                    end else if (w_q_valid) begin
                        r_state     <= c_st_merge;
                        r_j         <= '0;
                        r_slice_act <= 1'b1;
                    end else begin
                        r_state   <= c_st_drop;
                        r_pkt_end <= 1'b0;
                        r_phv_end <= 1'b0;
                        if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                    end
                end
                c_st_merge: begin
                    o_pkt_valid <= 1'b1;
                    o_pkt       <= r_slice_act ? {w_pkt_q[133:128], w_hdr_word} : w_pkt_q;
                    if (w_slice_pop) begin
                        r_j <= '0;
                        if (w_q_tail) r_slice_act <= 1'b0;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                    // A slice still open at the packet tail leaves the rest of the PHV to flush.
                    if (w_pkt_q_tail) begin
                        r_state <= (r_slice_act && !w_q_tail) ? c_st_flush : c_st_idle;
                    end else if (w_slice_pop && w_q_tail) begin
                        o_err_mismatch <= 1'b1;
                    end
                end
                c_st_flush: begin
                    if (w_q_tail) begin
                        o_err_mismatch <= 1'b1;
                        r_state        <= c_st_idle;
                    end
                end
                c_st_drop: begin
                    if (w_pkt_last) r_pkt_end <= 1'b1;
                    if (w_phv_last) r_phv_end <= 1'b1;
                    if ((r_pkt_end || w_pkt_last) && (r_phv_end || w_phv_last)) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_phv_pkt_deparser.sv
`default_nettype none
// Bench for phv_pkt_deparser: table vectors, hand-written corner sequences and
// random packets, all checked against a word-level reference model.
module tb_phv_pkt_deparser;
    localparam int HW = 512;
    localparam int TW = 8;
    localparam int PN = HW / 128;
    localparam int SB = 0;
    localparam int TB = 1;
    localparam int VB = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pkt_valid = 1'b0;
    logic [133:0]    pkt_in = '0;
    logic            phv_valid = 1'b0;
    logic [HW+TW-1:0] phv_in = '0;
    logic            o_valid;
    logic [133:0]    o_pkt;
    logic            ovf;
    logic            mism;
    logic [15:0]     drop_cnt;

    always #5 clk = ~clk;

    phv_pkt_deparser dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pkt_valid    (pkt_valid),
        .i_pkt          (pkt_in),
        .i_phv_valid    (phv_valid),
        .i_phv          (phv_in),
        .o_pkt_valid    (o_valid),
        .o_pkt          (o_pkt),
        .o_err_overflow (ovf),
        .o_err_mismatch (mism),
        .o_drop_cnt     (drop_cnt)
    );

    typedef struct {
        int nw;
        int ns;
        bit valid;
        int exp_words;
        int exp_mism;
        int exp_drop;
    } vec_t;

    vec_t             vecs[11];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    logic [133:0]     exp_q[$];
    logic [133:0]     pend_words[$];
    logic [HW+TW-1:0] pend_slices[$];
    logic [133:0]     cur_words[$];
    logic [HW+TW-1:0] cur_slices[$];
    int               mism_seen = 0;
    int               words_seen = 0;
    int               exp_drop = 0;
    int               exp_mism_tot = 0;
    int               first_cyc = -1;
    int               last_tail_cyc = 0;
    int               last_gap = -1;
    int               t_tail = 0;
    bit               in_pkt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mism) mism_seen++;
            if (in_pkt && !o_valid) begin
                total++;
                bad++;
                $display("FAIL word_gap: got idle cycle want contiguous word at cycle %0d", cyc);
                in_pkt = 1'b0;
            end
            if (o_valid) begin
                words_seen++;
                if (o_pkt[133:132] == 2'b01) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_gap = cyc - last_tail_cyc - 1;
                    in_pkt   = 1'b1;
                end
                if (o_pkt[133:132] == 2'b10) begin
                    last_tail_cyc = cyc;
                    in_pkt        = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h want no word", o_pkt);
                end else begin
                    check("out_word", o_pkt, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [HW+TW-1:0] rand_slice();
        logic [HW+TW-1:0] v = '0;
        for (int i = 0; i < (HW + TW + 31) / 32; i++) v = {v[HW+TW-33:0], 32'($urandom)};
        return v;
    endfunction

    // Reference: slice s covers words s*PN..s*PN+PN-1, word j of a slice is the
    // j-th 128b chunk counted from the header MSB; one mismatch if slice and word counts disagree.
    function automatic int model_pkt();
        int nw = cur_words.size();
        int ns = cur_slices.size();
        logic [133:0]  w;
        logic [HW-1:0] h;
        if (!cur_slices[0][HW+VB]) begin
            exp_drop++;
            return 0;
        end
        for (int i = 0; i < nw; i++) begin
            w = cur_words[i];
            if (i / PN < ns) begin
                h = cur_slices[i/PN][HW-1:0];
                h = h >> (128 * (PN - 1 - (i % PN)));
                w[127:0] = h[127:0];
            end
            exp_q.push_back(w);
        end
        return (((nw + PN - 1) / PN) != ns) ? 1 : 0;
    endfunction

    task automatic build_pkt(input int nw, input int ns, input bit valid);
        logic [HW+TW-1:0] sl;
        logic [1:0]       ty;
        cur_words.delete();
        cur_slices.delete();
        for (int w = 0; w < nw; w++) begin
            ty = (w == 0) ? 2'b01 : ((w == nw - 1) ? 2'b10 : 2'b11);
            cur_words.push_back({ty, 4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
        end
        for (int s = 0; s < ns; s++) begin
            sl = rand_slice();
            sl[HW+SB] = (s == 0);
            sl[HW+TB] = (s == ns - 1);
            if (s == 0) sl[HW+VB] = valid;
            cur_slices.push_back(sl);
        end
        exp_mism_tot += model_pkt();
        foreach (cur_words[i]) pend_words.push_back(cur_words[i]);
        foreach (cur_slices[i]) pend_slices.push_back(cur_slices[i]);
    endtask

    task automatic drive_slices();
        while (pend_slices.size() != 0) begin
            @(posedge clk); #1;
            phv_valid = 1'b1;
            phv_in    = pend_slices.pop_front();
        end
        @(posedge clk); #1;
        phv_valid = 1'b0;
    endtask

    task automatic drive_words();
        while (pend_words.size() != 0) begin
            @(posedge clk); #1;
            pkt_valid = 1'b1;
            pkt_in    = pend_words.pop_front();
        end
        t_tail = cyc + 1;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic send(input int nw, input int ns, input bit valid);
        build_pkt(nw, ns, valid);
        drive_slices();
        drive_words();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d words pending want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, mb, db;
        vecs[0]  = '{6,  2, 1'b1, 6,  0, 0};
        vecs[1]  = '{5,  1, 1'b0, 0,  0, 1};
        vecs[2]  = '{4,  1, 1'b1, 4,  0, 0};
        vecs[3]  = '{8,  1, 1'b1, 8,  1, 0};
        vecs[4]  = '{2,  2, 1'b1, 2,  1, 0};
        vecs[5]  = '{3,  1, 1'b1, 3,  0, 0};
        vecs[6]  = '{9,  3, 1'b1, 9,  0, 0};
        vecs[7]  = '{3,  3, 1'b0, 0,  0, 1};
        vecs[8]  = '{5,  2, 1'b1, 5,  0, 0};
        vecs[9]  = '{12, 2, 1'b1, 12, 1, 0};
        vecs[10] = '{2,  1, 1'b1, 2,  0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_pkt", o_pkt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_mism", mism, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3-word packet, single slice: header words overwrite data, latency 3.
        mb = mism_seen;
        send(3, 1, 1'b1);
        drain("first");
        check("latency", first_cyc - t_tail, 3);
        check("first_mism", mism_seen - mb, 0);

        foreach (vecs[i]) begin
            wb = words_seen;
            mb = mism_seen;
            db = int'(drop_cnt);
            send(vecs[i].nw, vecs[i].ns, vecs[i].valid);
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_words", i), words_seen - wb, vecs[i].exp_words);
            check($sformatf("vec%0d_mism", i), mism_seen - mb, vecs[i].exp_mism);
            check($sformatf("vec%0d_drop", i), int'(drop_cnt) - db, vecs[i].exp_drop);
        end

        // Back-to-back packets: at most two idle cycles between them.
        mb = mism_seen;
        build_pkt(3, 1, 1'b1);
        build_pkt(3, 1, 1'b1);
        drive_slices();
        drive_words();
        drain("b2b");
        check("b2b_gap_le2", (last_gap >= 0 && last_gap <= 2), 1);
        check("b2b_mism", mism_seen - mb, 0);

        // Stray slice without START ahead of a proper PHV.
        mb = mism_seen;
        wb = words_seen;
        begin
            logic [HW+TW-1:0] sl;
            sl = rand_slice();
            sl[HW+SB] = 1'b0;
            sl[HW+TB] = 1'b0;
            pend_slices.push_back(sl);
        end
        send(4, 1, 1'b1);
        drain("stray");
        check("stray_mism", mism_seen - mb, 1);
        check("stray_words", words_seen - wb, 4);

        // Random packets against the model.
        mb = mism_seen;
        exp_mism_tot = 0;
        for (int p = 0; p < 40; p++) begin
            send(int'($urandom_range(2, 12)), int'($urandom_range(1, 4)), ($urandom_range(0, 4) != 0));
        end
        drain("rand");
        check("rand_mism", mism_seen - mb, exp_mism_tot);
        check("rand_drop", drop_cnt, exp_drop);

        // Fill the packet FIFO with an unterminated packet, then overflow it.
        for (int w = 0; w < 512; w++) begin
            @(posedge clk); #1;
            pkt_valid = 1'b1;
            pkt_in    = {(w == 0) ? 2'b01 : 2'b11, 4'h5, 32'($urandom), 32'($urandom), 32'($urandom), 32'(w)};
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(negedge clk);
        check("full_no_ovf", ovf, 0);
        @(posedge clk); #1;
        pkt_valid = 1'b1;
        pkt_in    = {2'b11, 4'h0, 128'h1};
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(negedge clk);
        check("ovf_set", ovf, 1);
        repeat (5) @(negedge clk);
        check("ovf_sticky", ovf, 1);
        check("drop_before_rst", drop_cnt, exp_drop);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_valid", o_valid, 0);
        check("rst2_pkt", o_pkt, 0);
        check("rst2_ovf", ovf, 0);
        check("rst2_mism", mism, 0);
        check("rst2_drop", drop_cnt, 0);
        exp_q.delete();
        exp_drop = 0;

        // Headless words after reset must be discarded.
        pend_words.push_back({2'b11, 4'h3, 128'hDEAD});
        pend_words.push_back({2'b10, 4'h3, 128'hBEEF});
        drive_words();
        mb = mism_seen;
        wb = words_seen;
        send(3, 1, 1'b1);
        drain("post_rst");
        check("post_rst_words", words_seen - wb, 3);
        check("post_rst_mism", mism_seen - mb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
